multicycle_ctrl: RTL and testbench

Control unit for the multicycle ARM-subset datapath, successor to the single-cycle decoder. A Moore state machine sequences fetch, decode, execute, memory and write-back over 3–5 cycles per instruction. It owns the NZCV flags register and the condition check, and drives every datapath enable and mux select. The ALU-control width is parametrised, and there is an optional multiply path.

---
 rtl/mc_pkg.sv | 70 +++++++
 rtl/multicycle_ctrl_cond.sv | 35 +++
 rtl/multicycle_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit.
// States, ALU op codes, condition codes and datapath select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
`ifdef MC_MUL_EN
    , S_MULX
`endif
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;

  localparam logic [3:0] C_EQ = 4'h0;
  localparam logic [3:0] C_NE = 4'h1;
  localparam logic [3:0] C_CS = 4'h2;
  localparam logic [3:0] C_CC = 4'h3;
  localparam logic [3:0] C_MI = 4'h4;
  localparam logic [3:0] C_PL = 4'h5;
  localparam logic [3:0] C_VS = 4'h6;
  localparam logic [3:0] C_VC = 4'h7;
  localparam logic [3:0] C_HI = 4'h8;
  localparam logic [3:0] C_LS = 4'h9;
  localparam logic [3:0] C_GE = 4'hA;
  localparam logic [3:0] C_LT = 4'hB;
  localparam logic [3:0] C_GT = 4'hC;
  localparam logic [3:0] C_LE = 4'hD;
  localparam logic [3:0] C_AL = 4'hE;

  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_DATA   = 2'b01;
  localparam logic [1:0] RS_ALURES = 2'b10;

  localparam logic [1:0] SB_RD2  = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Map the data-processing cmd field to an ALU op; unknown -> ADD.
  function automatic logic [2:0] alu_dec(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_dec = ALU_ADD;
      4'b0010: alu_dec = ALU_SUB;
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      4'b0001: alu_dec = ALU_EOR;
      4'b1010: alu_dec = ALU_SUB;
      4'b1000: alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_cond.sv
// Condition check: evaluates an ARM condition field against NZCV.
// Purely combinational.
module cond_check
  import mc_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] NZCV,
  output logic       CondEx
);

  logic n, z, c, v;
  assign {n, z, c, v} = NZCV;

  // Condition decode; AL and the 1111 encoding both pass.
  always_comb begin
    case (Cond)
      C_EQ:    CondEx = z;
      C_NE:    CondEx = ~z;
      C_CS:    CondEx = c;
      C_CC:    CondEx = ~c;
      C_MI:    CondEx = n;
      C_PL:    CondEx = ~n;
      C_VS:    CondEx = v;
      C_VC:    CondEx = ~v;
      C_HI:    CondEx = c & ~z;
      C_LS:    CondEx = ~c | z;
      C_GE:    CondEx = (n == v);
      C_LT:    CondEx = (n != v);
      C_GT:    CondEx = ~z & (n == v);
      C_LE:    CondEx = z | (n != v);
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control FSM with NZCV flags and condition check.
// Optional multiply path enabled by defining MC_MUL_EN.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int         ACW         = 3,
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Instr,
  input  logic [3:0]      ALUFlags,
  output logic            PCWrite,
  output logic            AdrSrc,
  output logic            IRWrite,
  output logic            MemWrite,
  output logic            RegWrite,
  output logic [1:0]      ResultSrc,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ImmSrc,
  output logic [1:0]      RegSrc,
  output logic [ACW-1:0]  ALUControl,
  output logic [3:0]      Flags,
  output logic            Undef
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];

  logic unused_bits;
  assign unused_bits = ^{Instr[19:16], Instr[11:0]};

  state_e     state_q, state_d;
  logic       condex_q, condex;
  logic [3:0] flags_q, flags_d;
  logic [2:0] dp_op, alu_op;
  logic       rd15, is_mul, cv_upd;
  logic       pcw, irw, mw, rw;

  assign dp_op  = alu_dec(funct[4:1]);
  assign rd15   = (rd == 4'hF);
  assign cv_upd = (dp_op == ALU_ADD) | (dp_op == ALU_SUB);

`ifdef MC_MUL_EN
  assign is_mul = (op == OP_DP) & (funct[5:1] == 5'b0)
                & (Instr[7:4] == 4'b1001);
`else
  assign is_mul = 1'b0;
`endif

  cond_check u_cond (
    .Cond   (cond),
    .NZCV   (flags_q),
    .CondEx (condex)
  );

  // Next-state sequencing over the instruction class.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI: begin
        if (funct[4:3] == 2'b10) state_d = S_FETCH;
        else                     state_d = S_ALUWB;
`ifdef MC_MUL_EN
        if (state_q == S_EXECR && is_mul) state_d = S_MULX;
`endif
      end
`ifdef MC_MUL_EN
      S_MULX:   state_d = S_ALUWB;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Flags update at the end of an execute state when S and condition hold.
  always_comb begin
    flags_d = flags_q;
    if (condex_q && funct[0]) begin
      if ((state_q == S_EXECR && !is_mul) || state_q == S_EXECI) begin
        flags_d[3:2] = ALUFlags[3:2];
        if (cv_upd) flags_d[1:0] = ALUFlags[1:0];
      end
`ifdef MC_MUL_EN
      if (state_q == S_MULX) flags_d[3:2] = ALUFlags[3:2];
`endif
    end
  end

  // State, latched condition result and NZCV register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      condex_q <= 1'b0;
      flags_q  <= FLAGS_RESET;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if (state_q == S_DECODE) condex_q <= condex;
    end
  end

  // Moore decode of datapath controls from the current state.
  always_comb begin
    pcw       = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RS_ALUOUT;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SB_RD2;
    alu_op    = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        irw       = 1'b1;
        pcw       = 1'b1;
        ResultSrc = RS_ALURES;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SB_FOUR;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SB_FOUR;
      end
      S_MEMADR: ALUSrcB = SB_IMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RS_DATA;
        rw        = condex_q & ~rd15;
        pcw       = condex_q & rd15;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mw     = condex_q;
      end
      S_EXECR: alu_op = dp_op;
      S_EXECI: begin
        ALUSrcB = SB_IMM;
        alu_op  = dp_op;
      end
      S_ALUWB: begin
        rw  = condex_q & ~rd15;
        pcw = condex_q & rd15;
      end
      S_BRANCH: begin
        ALUSrcB   = SB_IMM;
        ResultSrc = RS_ALURES;
        pcw       = condex_q;
      end
`ifdef MC_MUL_EN
      S_MULX: alu_op = ALU_MUL;
`endif
      default: ;
    endcase
  end

  // Write enables are held off for as long as reset is asserted.
  assign PCWrite    = pcw & ~reset;
  assign IRWrite    = irw & ~reset;
  assign MemWrite   = mw & ~reset;
  assign RegWrite   = rw & ~reset;
  assign ALUControl = ACW'(alu_op);
  assign ImmSrc     = op;
  assign RegSrc     = {(op == OP_MEM) & ~funct[0], op == OP_BR};
  assign Flags      = flags_q;
  assign Undef      = (state_q == S_DECODE) & (op == 2'b11);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control
// vectors are queued per instruction and compared mid-cycle.
module tb_multicycle_ctrl;

  localparam int SF  = 0;
  localparam int SD  = 1;
  localparam int SMA = 2;
  localparam int SMR = 3;
  localparam int SMB = 4;
  localparam int SMW = 5;
  localparam int SER = 6;
  localparam int SEI = 7;
  localparam int SAW = 8;
  localparam int SB  = 9;
  localparam int SMX = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic        ALUSrcA, Undef;
  logic [3:0]  ALUControl;
  logic [3:0]  Flags;
  logic [14:0] dv;

  int nvec = 0;
  int nbad = 0;
  logic [14:0] sbq[$];
  string       snq[$];

  multicycle_ctrl #(.ACW(4), .FLAGS_RESET(4'b0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .Flags      (Flags),
    .Undef      (Undef)
  );

  always #5 clk = ~clk;

  assign dv = {PCWrite, IRWrite, MemWrite, RegWrite, Undef, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl};

  function automatic logic [31:0] mk(logic [3:0] c, logic [1:0] o,
                                     logic [5:0] f, logic [3:0] rd,
                                     logic [3:0] mid);
    return {c, o, f, 4'h0, rd, 4'h0, mid, 4'h0};
  endfunction

  // Expected controls per state, straight from the state descriptions.
  function automatic logic [14:0] expv(int st, logic ce, logic rd15,
                                       logic [2:0] fop, logic und,
                                       logic rst);
    logic pcw, irw, mw, rw, adr, asa;
    logic [1:0] rs, asb;
    logic [2:0] alu;
    pcw = 0; irw = 0; mw = 0; rw = 0; adr = 0; asa = 0;
    rs = 2'b00; asb = 2'b00; alu = 3'd0;
    case (st)
      SF: begin
        pcw = 1; irw = 1; rs = 2'b10; asa = 1; asb = 2'b10;
      end
      SD: begin asa = 1; asb = 2'b10; end
      SMA: asb = 2'b01;
      SMR: adr = 1;
      SMB: begin rs = 2'b01; rw = ce & ~rd15; pcw = ce & rd15; end
      SMW: begin adr = 1; mw = ce; end
      SER: alu = fop;
      SEI: begin asb = 2'b01; alu = fop; end
      SAW: begin rw = ce & ~rd15; pcw = ce & rd15; end
      SB:  begin asb = 2'b01; rs = 2'b10; pcw = ce; end
      SMX: alu = 3'd5;
      default: ;
    endcase
    if (rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {pcw, irw, mw, rw, und, adr, rs, asa, asb, 1'b0, alu};
  endfunction

  task automatic push(string n, logic [14:0] v);
    sbq.push_back(v);
    snq.push_back(n);
  endtask

  task automatic drain();
    logic [14:0] w;
    string n;
    while (sbq.size() > 0) begin
      #1;
      w = sbq.pop_front();
      n = snq.pop_front();
      nvec++;
      if (dv !== w) begin
        nbad++;
        $display("FAIL %s: got %b want %b", n, dv, w);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Instr = mk(4'hE, 2'b01, 6'b011000, 4'd3, 4'd0);
    ALUFlags = 4'b1111;
    repeat (2) @(negedge clk);
    push("reset_out", expv(SF, 0, 0, 0, 0, 1));
    drain();
    nvec++;
    if (Flags !== 4'b0000) begin
      nbad++;
      $display("FAIL reset_flags: got %b want 0000", Flags);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    Instr = mk(4'hE, 2'b00, 6'b001000, 4'd1, 4'd0);
    ALUFlags = 4'b1111;
    push("add_f", expv(SF, 0, 0, 0, 0, 0));
    push("add_d", expv(SD, 0, 0, 0, 0, 0));
    push("add_x", expv(SER, 0, 0, 3'd0, 0, 0));
    push("add_wb", expv(SAW, 1, 0, 0, 0, 0));
    drain();
    nvec++;
    if (Flags !== 4'b0000) begin
      nbad++;
      $display("FAIL add_noS_flags: got %b want 0000", Flags);
    end
  endtask

  task automatic test_mem_condfail();
    Instr = mk(4'h0, 2'b01, 6'b011001, 4'd2, 4'd0);
    push("ldr_f", expv(SF, 0, 0, 0, 0, 0));
    push("ldr_d", expv(SD, 0, 0, 0, 0, 0));
    push("ldr_ma", expv(SMA, 0, 0, 0, 0, 0));
    push("ldr_mr", expv(SMR, 0, 0, 0, 0, 0));
    push("ldr_wb", expv(SMB, 0, 0, 0, 0, 0));
    drain();
    Instr = mk(4'h0, 2'b01, 6'b011000, 4'd2, 4'd0);
    #1;
    nvec++;
    if ({RegSrc, ImmSrc} !== 4'b1001) begin
      nbad++;
      $display("FAIL str_src: got %b want 1001", {RegSrc, ImmSrc});
    end
    push("streq_f", expv(SF, 0, 0, 0, 0, 0));
    push("streq_d", expv(SD, 0, 0, 0, 0, 0));
    push("streq_ma", expv(SMA, 0, 0, 0, 0, 0));
    push("streq_mw", expv(SMW, 0, 0, 0, 0, 0));
    drain();
    Instr = mk(4'hE, 2'b01, 6'b011000, 4'd2, 4'd0);
    push("stral_f", expv(SF, 0, 0, 0, 0, 0));
    push("stral_d", expv(SD, 0, 0, 0, 0, 0));
    push("stral_ma", expv(SMA, 0, 0, 0, 0, 0));
    push("stral_mw", expv(SMW, 1, 0, 0, 0, 0));
    drain();
  endtask

  task automatic test_cmp_branch();
    Instr = mk(4'hE, 2'b00, 6'b010101, 4'd0, 4'd0);
    ALUFlags = 4'b0100;
    push("cmp_f", expv(SF, 0, 0, 0, 0, 0));
    push("cmp_d", expv(SD, 0, 0, 0, 0, 0));
    push("cmp_x", expv(SER, 0, 0, 3'd1, 0, 0));
    drain();
    nvec++;
    if (Flags !== 4'b0100) begin
      nbad++;
      $display("FAIL cmp_flags: got %b want 0100", Flags);
    end
    ALUFlags = 4'b0000;
    Instr = mk(4'h1, 2'b10, 6'b100000, 4'd0, 4'd0);
    #1;
    nvec++;
    if ({RegSrc, ImmSrc} !== 4'b0110) begin
      nbad++;
      $display("FAIL b_src: got %b want 0110", {RegSrc, ImmSrc});
    end
    push("bne_f", expv(SF, 0, 0, 0, 0, 0));
    push("bne_d", expv(SD, 0, 0, 0, 0, 0));
    push("bne_b", expv(SB, 0, 0, 0, 0, 0));
    drain();
    Instr = mk(4'h0, 2'b10, 6'b100000, 4'd0, 4'd0);
    push("beq_f", expv(SF, 0, 0, 0, 0, 0));
    push("beq_d", expv(SD, 0, 0, 0, 0, 0));
    push("beq_b", expv(SB, 1, 0, 0, 0, 0));
    drain();
  endtask

  task automatic test_dp_flags();
    Instr = mk(4'hE, 2'b00, 6'b001001, 4'd15, 4'd0);
    ALUFlags = 4'b1001;
    push("pc_f", expv(SF, 0, 0, 0, 0, 0));
    push("pc_d", expv(SD, 0, 0, 0, 0, 0));
    push("pc_x", expv(SER, 0, 0, 3'd0, 0, 0));
    push("pc_wb", expv(SAW, 1, 1, 0, 0, 0));
    drain();
    nvec++;
    if (Flags !== 4'b1001) begin
      nbad++;
      $display("FAIL adds_flags: got %b want 1001", Flags);
    end
    Instr = mk(4'hE, 2'b00, 6'b000001, 4'd4, 4'd0);
    ALUFlags = 4'b0110;
    push("ands_f", expv(SF, 0, 0, 0, 0, 0));
    push("ands_d", expv(SD, 0, 0, 0, 0, 0));
    push("ands_x", expv(SER, 0, 0, 3'd2, 0, 0));
    push("ands_wb", expv(SAW, 1, 0, 0, 0, 0));
    drain();
    nvec++;
    if (Flags !== 4'b0101) begin
      nbad++;
      $display("FAIL ands_flags: got %b want 0101", Flags);
    end
    Instr = mk(4'hE, 2'b00, 6'b111000, 4'd5, 4'd0);
    push("orri_f", expv(SF, 0, 0, 0, 0, 0));
    push("orri_d", expv(SD, 0, 0, 0, 0, 0));
    push("orri_x", expv(SEI, 0, 0, 3'd3, 0, 0));
    push("orri_wb", expv(SAW, 1, 0, 0, 0, 0));
    drain();
    Instr = mk(4'hC, 2'b00, 6'b000011, 4'd6, 4'd0);
    ALUFlags = 4'b1010;
    push("eorgt_f", expv(SF, 0, 0, 0, 0, 0));
    push("eorgt_d", expv(SD, 0, 0, 0, 0, 0));
    push("eorgt_x", expv(SER, 0, 0, 3'd4, 0, 0));
    push("eorgt_wb", expv(SAW, 0, 0, 0, 0, 0));
    drain();
    nvec++;
    if (Flags !== 4'b0101) begin
      nbad++;
      $display("FAIL eorgt_flags: got %b want 0101", Flags);
    end
  endtask

  task automatic test_undef();
    Instr = mk(4'hE, 2'b11, 6'b000000, 4'd0, 4'd0);
    push("und_f", expv(SF, 0, 0, 0, 0, 0));
    push("und_d", expv(SD, 0, 0, 0, 1, 0));
    drain();
  endtask

  task automatic test_reset_mid();
    Instr = mk(4'hE, 2'b01, 6'b011001, 4'd7, 4'd0);
    push("rm_f", expv(SF, 0, 0, 0, 0, 0));
    push("rm_d", expv(SD, 0, 0, 0, 0, 0));
    push("rm_ma", expv(SMA, 0, 0, 0, 0, 0));
    drain();
    reset = 1'b1;
    push("rm_rst", expv(SF, 0, 0, 0, 0, 1));
    drain();
    nvec++;
    if (Flags !== 4'b0000) begin
      nbad++;
      $display("FAIL rm_flags: got %b want 0000", Flags);
    end
    reset = 1'b0;
    Instr = mk(4'hE, 2'b00, 6'b001000, 4'd1, 4'd0);
    push("rm2_f", expv(SF, 0, 0, 0, 0, 0));
    push("rm2_d", expv(SD, 0, 0, 0, 0, 0));
    push("rm2_x", expv(SER, 0, 0, 3'd0, 0, 0));
    push("rm2_wb", expv(SAW, 1, 0, 0, 0, 0));
    drain();
  endtask

  task automatic test_mul();
    Instr = mk(4'hE, 2'b00, 6'b000001, 4'd8, 4'b1001);
    ALUFlags = 4'b1011;
    push("mul_f", expv(SF, 0, 0, 0, 0, 0));
    push("mul_d", expv(SD, 0, 0, 0, 0, 0));
    push("mul_x", expv(SER, 0, 0, 3'd2, 0, 0));
`ifdef MC_MUL_EN
    push("mul_mx", expv(SMX, 0, 0, 0, 0, 0));
`endif
    push("mul_wb", expv(SAW, 1, 0, 0, 0, 0));
    drain();
    nvec++;
    if (Flags !== 4'b1000) begin
      nbad++;
      $display("FAIL mul_flags: got %b want 1000", Flags);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    Instr = '0;
    ALUFlags = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_mem_condfail();
    test_cmp_branch();
    test_dp_flags();
    test_undef();
    test_reset_mid();
    test_mul();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
